change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_CYC, default 4, hopper eject pulse width in clk cycles (range 1..15).
REQ-002 Parameter TIMEOUT_CYC, default 64, cycles to wait for coin-drop confirmation after each pulse (range 2..255).
REQ-003 Parameter MAX_RETRY, default 2, re-fire attempts per coin before fault (range 0..3).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 change_in  in  2  change owed this cycle: 00 none, 01 = 5 rs, 10 = 10 rs, 11 illegal.
REQ-007 coin_sense  in  1  asynchronous hopper drop sensor, high while a coin passes.
REQ-008 hopper_fire  out  1  eject drive to the 5 rs coin hopper, registered.
REQ-009 pending  out  4  count of 5 rs coins still owed, registered.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 done  out  1  one-cycle pulse when pending reaches 0 through a confirmed coin.
REQ-012 fault  out  1  high in FAULT state; sticky until rst.

Function
REQ-013 All change is paid in 5 rs coins; change_in 01 adds 1 to pending, 10 adds 2, 00 and 11 add 0.
REQ-014 change_in is sampled every cycle regardless of FSM state, except in FAULT, where it is ignored.
REQ-015 A change_in value sampled at edge N is reflected in pending after edge N.
REQ-016 The add and a confirmed-coin decrement in the same cycle both apply: pending = pending + add - 1.
REQ-017 If the sum would exceed 15, pending holds 15 and the FSM enters FAULT on the same edge.
REQ-018 coin_sense passes through a 2-flop synchronizer; a rising edge on the synchronized signal forms a one-cycle coin event, visible to the FSM 2 edges after the raw input is first sampled high.
REQ-019 FSM states: IDLE, FIRE, WAIT, GAP, FAULT; reset state is IDLE.
REQ-020 IDLE: when pending > 0, go to FIRE; hopper_fire rises on the edge after pending first becomes non-zero.
REQ-021 FIRE: hopper_fire = 1 for exactly PULSE_CYC cycles, then go to WAIT with the timeout timer cleared.
REQ-022 WAIT: hopper_fire = 0; a coin event decrements pending, clears the retry count and moves to GAP.
REQ-023 WAIT: if the timer reaches TIMEOUT_CYC with no coin event, increment the retry count; go to FIRE if retries <= MAX_RETRY, else go to FAULT.
REQ-024 GAP: hopper_fire = 0 for exactly 2 cycles, then go to IDLE.
REQ-025 Coin events outside WAIT are ignored; they never change pending.
REQ-026 A second coin event within the same WAIT is impossible, because the state leaves WAIT on the first event.
REQ-027 done asserts on the edge where the WAIT decrement leaves pending = 0 (this includes the case add = 0 in REQ-016).
REQ-028 FAULT: hopper_fire = 0, fault = 1, pending frozen; only rst exits.

Reset
REQ-029 On rst: state IDLE, pending 0, retry count 0, timers 0, synchronizer flops 0, hopper_fire 0, done 0, fault 0, busy 0.
REQ-030 rst has priority over all other inputs, including change_in in the same cycle.
REQ-031 rst asserted mid-FIRE or mid-WAIT discards owed change; hopper_fire is 0 after that edge.

Verification
REQ-032 Bench shall cover:
- rst, then change_in = 10 for 1 cycle, with coin_sense pulsed 10 cycles after each hopper_fire fall -> two 4-cycle hopper_fire bursts; pending 2 -> 1 -> 0; single done pulse; busy returns to 0.
- change_in = 01, coin_sense held 0 -> 3 hopper_fire bursts, each followed by 64 WAIT cycles; then fault = 1, pending = 1, no further bursts until rst.
- change_in = 10 for 8 consecutive cycles, no coin_sense -> pending saturates at 15, fault = 1 on the saturating edge.
- In WAIT with pending = 2, apply change_in = 01 on the same cycle as the coin event -> pending = 2, no done pulse.
- coin_sense pulses in IDLE with pending = 0 -> pending stays 0, no done, hopper_fire stays 0.
- rst on the 2nd cycle of FIRE -> hopper_fire = 0 and pending = 0 on the next edge; FSM is in IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: accumulates 5 rs coins owed and drives a coin hopper,
// confirming each eject through a synchronized drop sensor with retries.
module change_dispenser #(
   parameter int PULSE_CYC   = 4,
   parameter int TIMEOUT_CYC = 64,
   parameter int MAX_RETRY   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] change_in,
   input  logic       coin_sense,
   output logic       hopper_fire,
   output logic [3:0] pending,
   output logic       busy,
   output logic       done,
   output logic       fault
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FIRE  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic [7:0] PULSE_LAST   = 8'(PULSE_CYC - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [2:0] RETRY_LIM    = 3'(MAX_RETRY);

   state_t     state_r;
   logic       sync1_r;
   logic       sync2_r;
   logic       sync3_r;
   logic [7:0] timer_r;
   logic [2:0] retry_r;

   logic       coin_ev_s;
   logic [1:0] add_s;
   logic       dec_s;
   logic [4:0] sum_s;

   // Decode the amount owed this cycle and the next pending value.
   always_comb begin
      add_s = 2'd0;
      case (change_in)
         2'b01:   add_s = 2'd1;
         2'b10:   add_s = 2'd2;
         default: add_s = 2'd0;
      endcase
      coin_ev_s = sync2_r & ~sync3_r;
      dec_s     = (state_r == ST_WAIT) && coin_ev_s;
      sum_s     = {1'b0, pending} + {3'b000, add_s} - {4'b0000, dec_s};
   end

   assign busy = (state_r != ST_IDLE);

   // Synchronizer, pending accumulator and dispense FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         sync1_r     <= 1'b0;
         sync2_r     <= 1'b0;
         sync3_r     <= 1'b0;
         timer_r     <= 8'd0;
         retry_r     <= 3'd0;
         pending     <= 4'd0;
         hopper_fire <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
      end else begin
         sync1_r <= coin_sense;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         done    <= 1'b0;
         // Overflow beats any state transition on the same edge.
         if ((state_r != ST_FAULT) && (sum_s > 5'd15)) begin
            pending     <= 4'd15;
            state_r     <= ST_FAULT;
            hopper_fire <= 1'b0;
            fault       <= 1'b1;
         end else begin
            if (state_r != ST_FAULT) begin
               pending <= sum_s[3:0];
            end
            done <= dec_s && (sum_s == 5'd0);
            case (state_r)
               ST_IDLE: begin
                  if (pending != 4'd0) begin
                     state_r     <= ST_FIRE;
                     hopper_fire <= 1'b1;
                     timer_r     <= 8'd0;
                  end
               end
               ST_FIRE: begin
                  if (timer_r == PULSE_LAST) begin
                     state_r     <= ST_WAIT;
                     hopper_fire <= 1'b0;
                     timer_r     <= 8'd0;
                  end else begin
                     timer_r <= timer_r + 8'd1;
                  end
               end
               ST_WAIT: begin
                  if (coin_ev_s) begin
                     state_r <= ST_GAP;
                     retry_r <= 3'd0;
                     timer_r <= 8'd0;
                  end else if (timer_r == TIMEOUT_LAST) begin
                     timer_r <= 8'd0;
                     retry_r <= retry_r + 3'd1;
                     if ((retry_r + 3'd1) <= RETRY_LIM) begin
                        state_r     <= ST_FIRE;
                        hopper_fire <= 1'b1;
                     end else begin
                        state_r <= ST_FAULT;
                        fault   <= 1'b1;
                     end
                  end else begin
                     timer_r <= timer_r + 8'd1;
                  end
               end
               ST_GAP: begin
                  if (timer_r == 8'd1) begin
                     state_r <= ST_IDLE;
                     timer_r <= 8'd0;
                  end else begin
                     timer_r <= timer_r + 8'd1;
                  end
               end
               ST_FAULT: begin
                  hopper_fire <= 1'b0;
                  fault       <= 1'b1;
               end
               default: begin
                  state_r     <= ST_IDLE;
                  hopper_fire <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_change_dispenser;

   localparam int P_PULSE = 4;
   localparam int P_TMO   = 64;
   localparam int P_RETRY = 2;

   localparam int M_IDLE  = 0;
   localparam int M_FIRE  = 1;
   localparam int M_WAIT  = 2;
   localparam int M_GAP   = 3;
   localparam int M_FAULT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] change_in;
   logic       coin_sense;
   logic       hopper_fire;
   logic [3:0] pending;
   logic       busy;
   logic       done;
   logic       fault;

   int tests = 0;
   int fails = 0;

   // Behavioural model: phase, cycles left in phase, tries, coins owed.
   int m_mode, m_left, m_tries, m_pend;
   bit m_hf, m_done, m_h1, m_h2, m_h3;

   change_dispenser #(.PULSE_CYC(P_PULSE), .TIMEOUT_CYC(P_TMO), .MAX_RETRY(P_RETRY)) dut (
      .clk(clk), .rst(rst), .change_in(change_in), .coin_sense(coin_sense),
      .hopper_fire(hopper_fire), .pending(pending), .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_edge(input bit r, input logic [1:0] ch, input bit cs);
      int add, sum, old;
      bit ev;
      if (r) begin
         m_mode = M_IDLE; m_left = 0; m_tries = 0; m_pend = 0;
         m_hf = 0; m_done = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
      end else begin
         ev = (m_mode == M_WAIT) && m_h2 && !m_h3;
         m_h3 = m_h2; m_h2 = m_h1; m_h1 = cs;
         m_done = 0;
         if (m_mode != M_FAULT) begin
            add = (ch == 2'b01) ? 1 : ((ch == 2'b10) ? 2 : 0);
            old = m_pend;
            sum = m_pend + add - (ev ? 1 : 0);
            if (sum > 15) begin
               m_pend = 15; m_mode = M_FAULT; m_hf = 0;
            end else begin
               m_pend = sum;
               m_done = ev && (sum == 0);
               if (m_mode == M_IDLE) begin
                  if (old > 0) begin m_mode = M_FIRE; m_left = P_PULSE; m_hf = 1; end
               end else if (m_mode == M_FIRE) begin
                  m_left--;
                  if (m_left == 0) begin m_mode = M_WAIT; m_left = P_TMO; m_hf = 0; end
               end else if (m_mode == M_WAIT) begin
                  if (ev) begin
                     m_mode = M_GAP; m_left = 2; m_tries = 0;
                  end else begin
                     m_left--;
                     if (m_left == 0) begin
                        m_tries++;
                        if (m_tries <= P_RETRY) begin m_mode = M_FIRE; m_left = P_PULSE; m_hf = 1; end
                        else m_mode = M_FAULT;
                     end
                  end
               end else if (m_mode == M_GAP) begin
                  m_left--;
                  if (m_left == 0) m_mode = M_IDLE;
               end
            end
         end
      end
   endtask

   task automatic step(input bit r, input logic [1:0] ch, input bit cs);
      rst = r; change_in = ch; coin_sense = cs;
      @(posedge clk);
      model_edge(r, ch, cs);
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1'b1, 2'b10, 1'b1);
      step(1'b1, 2'b10, 1'b1);
      tests++;
      if ({hopper_fire, pending, busy, done, fault} !== 8'b0) begin
         fails++;
         $display("FAIL reset_outputs: got hf=%0b pend=%0d busy=%0b done=%0b fault=%0b required all 0",
                  hopper_fire, pending, busy, done, fault);
      end
      step(1'b0, 2'b00, 1'b0);
      tests++;
      if (pending !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: got pend=%0d busy=%0b required 0 0", pending, busy);
      end
   endtask

   task automatic test_two_coins();
      int cd = -1, blen = 0, bursts = 0, bad = 0, done_cnt = 0;
      bit prev_hf = 0, cs;
      int trace[$];
      step(1'b1, 2'b00, 1'b0);
      step(1'b0, 2'b10, 1'b0);
      trace.push_back(int'(pending));
      for (int i = 0; i < 200; i++) begin
         cs = (cd == 0);
         if (cd >= 0) cd--;
         step(1'b0, 2'b00, cs);
         if (hopper_fire) blen++;
         else if (prev_hf) begin
            bursts++;
            if (blen != P_PULSE) bad++;
            blen = 0;
            cd = 9;
         end
         if (done) done_cnt++;
         if (int'(pending) != trace[trace.size()-1]) trace.push_back(int'(pending));
         prev_hf = hopper_fire;
      end
      tests++;
      if (bursts != 2 || bad != 0) begin
         fails++;
         $display("FAIL two_coin_bursts: got %0d bursts (%0d wrong length) required 2 of %0d", bursts, bad, P_PULSE);
      end
      tests++;
      if (trace.size() != 3 || trace[0] != 2 || trace[1] != 1 || trace[2] != 0) begin
         fails++;
         $display("FAIL two_coin_pending_trace: got %0d values ending %0d required 2,1,0",
                  trace.size(), trace[trace.size()-1]);
      end
      tests++;
      if (done_cnt != 1 || busy !== 1'b0 || fault !== 1'b0) begin
         fails++;
         $display("FAIL two_coin_done_busy: got done_cnt=%0d busy=%0b fault=%0b required 1 0 0", done_cnt, busy, fault);
      end
   endtask

   task automatic test_retry_fault();
      int bursts = 0, low = 0, bad_wait = 0, extra = 0, moved = 0;
      bit prev_hf = 0;
      step(1'b1, 2'b00, 1'b0);
      step(1'b0, 2'b01, 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 2'b00, 1'b0);
         if (hopper_fire && !prev_hf && bursts > 0 && low != P_TMO) bad_wait++;
         if (!hopper_fire && prev_hf) begin bursts++; low = 0; end
         if (!hopper_fire) low++;
         prev_hf = hopper_fire;
      end
      tests++;
      if (bursts != 3 || bad_wait != 0) begin
         fails++;
         $display("FAIL retry_bursts: got %0d bursts, %0d bad waits required 3, 0", bursts, bad_wait);
      end
      tests++;
      if (fault !== 1'b1 || pending !== 4'd1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL retry_fault_state: got fault=%0b pend=%0d busy=%0b required 1 1 1", fault, pending, busy);
      end
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 2'b01, i[2]);
         if (hopper_fire) extra++;
         if (pending != 4'd1 || fault != 1'b1) moved++;
      end
      tests++;
      if (extra != 0 || moved != 0) begin
         fails++;
         $display("FAIL fault_frozen: got %0d fire cycles, %0d changed cycles required 0 0", extra, moved);
      end
   endtask

   task automatic test_saturate();
      int exp_p;
      step(1'b1, 2'b00, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 2'b10, 1'b0);
         exp_p = (2 * k > 15) ? 15 : 2 * k;
         tests++;
         if (pending !== 4'(exp_p) || fault !== (k == 8)) begin
            fails++;
            $display("FAIL saturate_step%0d: got pend=%0d fault=%0b required %0d %0b", k, pending, fault, exp_p, k == 8);
         end
      end
      tests++;
      if (hopper_fire !== 1'b0) begin
         fails++;
         $display("FAIL saturate_fire_off: got %0b required 0", hopper_fire);
      end
   endtask

   task automatic test_add_with_coin();
      bit seen = 0, found = 0;
      step(1'b1, 2'b00, 1'b0);
      step(1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 2'b00, 1'b0);
         if (hopper_fire) seen = 1;
         else if (seen) found = 1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL add_coin_reach_wait: got no burst end within 20 cycles required one");
      end
      step(1'b0, 2'b00, 1'b1);
      step(1'b0, 2'b00, 1'b0);
      step(1'b0, 2'b01, 1'b0);
      tests++;
      if (pending !== 4'd2 || done !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL add_with_coin: got pend=%0d done=%0b busy=%0b required 2 0 1", pending, done, busy);
      end
   endtask

   task automatic test_idle_coin();
      int bad = 0;
      step(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 2'b00, (i % 4) < 2);
         if (pending != 4'd0 || done != 1'b0 || hopper_fire != 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_coin_ignored: got %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_rst_in_fire();
      step(1'b1, 2'b00, 1'b0);
      step(1'b0, 2'b01, 1'b0);
      step(1'b0, 2'b00, 1'b0);
      tests++;
      if (hopper_fire !== 1'b1) begin
         fails++;
         $display("FAIL fire_rise: got hf=%0b required 1", hopper_fire);
      end
      step(1'b0, 2'b00, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      tests++;
      if (hopper_fire !== 1'b0 || pending !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_fire: got hf=%0b pend=%0d busy=%0b required 0 0 0", hopper_fire, pending, busy);
      end
      step(1'b0, 2'b00, 1'b0);
      tests++;
      if (hopper_fire !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_fire_after: got hf=%0b busy=%0b required 0 0", hopper_fire, busy);
      end
   endtask

   task automatic test_random();
      int hold = 0, sel;
      bit r, cs;
      logic [1:0] ch;
      step(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 399) == 0);
         sel = $urandom_range(0, 99);
         ch = (sel == 0) ? 2'b01 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b00;
         if (hold > 0) begin cs = 1; hold--; end
         else begin
            cs = 0;
            if ($urandom_range(0, 14) == 0) hold = $urandom_range(1, 3);
         end
         step(r, ch, cs);
         tests++;
         if (hopper_fire !== m_hf || pending !== 4'(m_pend) || done !== m_done ||
             busy !== (m_mode != M_IDLE) || fault !== (m_mode == M_FAULT)) begin
            fails++;
            $display("FAIL random_cycle%0d: got hf=%0b pend=%0d done=%0b busy=%0b fault=%0b required %0b %0d %0b %0b %0b",
                     i, hopper_fire, pending, done, busy, fault,
                     m_hf, m_pend, m_done, m_mode != M_IDLE, m_mode == M_FAULT);
         end
      end
   endtask

   initial begin
      rst = 1'b1; change_in = 2'b00; coin_sense = 1'b0;
      @(negedge clk);
      test_reset();
      test_two_coins();
      test_retry_fault();
      test_saturate();
      test_add_with_coin();
      test_idle_coin();
      test_rst_in_fire();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
